run_ctrl: RTL and testbench

- Parametrised run controller for the CPU cores.
- Generates per-core reset with a fixed hold time and staggered release, then counts run cycles.
- Reports completion when every enabled core asserts halt, or timeout when the cycle budget is exhausted.
- Sits between the system clock/reset and one or more CPU instances, replacing fixed-delay reset and fixed-time stop control.

---
 rtl/run_ctrl_pkg.sv | 27 ++
 rtl/run_ctrl_if.sv | 28 ++
 rtl/run_ctrl_halt_cap.sv | 44 ++++
 rtl/run_ctrl.sv | 146 ++++++++++++++
 tb/tb_run_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_STAGGER,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_e;

    localparam int DEF_N_CH       = 2;
    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_STAGGER    = 1;
    localparam int DEF_MAX_CYCLES = 40;
    localparam int DEF_CNT_W      = 16;

    // Bits needed to hold values 0 .. n-1, never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Control/status bundle between the run controller and whoever starts runs.
interface run_ctrl_if
    import run_ctrl_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic             clear;
    logic [N_CH-1:0]  ch_en;
    logic [N_CH-1:0]  halt_i;
    logic [N_CH-1:0]  core_rst;
    logic             running;
    logic             done;
    logic             timeout;
    logic [N_CH-1:0]  halted;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output start, clear, ch_en, halt_i,
        input  core_rst, running, done, timeout, halted, cycle_cnt
    );

    modport slave (
        input  start, clear, ch_en, halt_i,
        output core_rst, running, done, timeout, halted, cycle_cnt
    );
endinterface

// File: rtl/run_ctrl_halt_cap.sv
// Sticky per-core halt capture, masked by the run's enable set.
module run_ctrl_halt_cap #(
    parameter int N_CH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            capture_i,
    input  logic [N_CH-1:0] en_i,
    input  logic [N_CH-1:0] halt_i,
    output logic [N_CH-1:0] halted_o,
    output logic            all_halted_o
);
    logic [N_CH-1:0] halted_q;
    logic [N_CH-1:0] halted_d;
    logic [N_CH-1:0] halt_now;

    // Completion looks at what is already captured plus this cycle's halts.
    assign halt_now     = halted_q | (halt_i & en_i);
    assign all_halted_o = &(halt_now | ~en_i);
    assign halted_o     = halted_q;

    // Next captured mask: clear wins, otherwise accumulate only while running.
    always_comb begin
        // NOTE: default first so every path assigns halted_d and no latch is inferred.
        halted_d = halted_q;
        if (clr_i) begin
            halted_d = '0;
        end else if (capture_i) begin
            halted_d = halt_now;
        end
    end

    // Capture register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every register sits on the async reset so outputs are defined the instant rst falls.
        if (!rst) begin
            halted_q <= '0;
        end else begin
            // NOTE: non-blocking so all flops update together from pre-edge values.
            halted_q <= halted_d;
        end
    end
endmodule

// File: rtl/run_ctrl.sv
// Run controller: held core reset, staggered release, run-cycle budget.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int STAGGER    = DEF_STAGGER,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input logic       clk,
    input logic       rst,
    run_ctrl_if.slave bus
);
    localparam int REL_MAX = RST_CYCLES + (N_CH - 1) * STAGGER;
    localparam int CNT_IW  = clog2(REL_MAX + 1);

    if (N_CH < 1)                      begin : g_bad_n_ch   $error("N_CH must be at least 1");            end
    if (RST_CYCLES < 1)                begin : g_bad_rst    $error("RST_CYCLES must be at least 1");      end
    if (MAX_CYCLES < 1)                begin : g_bad_max    $error("MAX_CYCLES must be at least 1");      end
    if ((MAX_CYCLES >> CNT_W) != 0)    begin : g_bad_cnt_w  $error("MAX_CYCLES does not fit CNT_W");      end
    if ((REL_MAX >> CNT_W) != 0)       begin : g_bad_rel    $error("reset/stagger span does not fit CNT_W"); end

    state_e            state_q, state_d;
    logic [CNT_IW-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [N_CH-1:0]   en_q, en_d;
    logic [N_CH-1:0]   core_rst_q, core_rst_d;
    logic              running_q, done_q, timeout_q;
    logic [CNT_IW-1:0] last_rel;
    logic              start_ok;
    logic              all_halted;
    logic [N_CH-1:0]   halted;

    assign start_ok = bus.start && !bus.clear &&
                      (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_TIMEOUT);

    run_ctrl_halt_cap #(.N_CH(N_CH)) u_halt_cap (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (bus.clear || start_ok),
        .capture_i    ((state_q == ST_RUN) && !bus.clear),
        .en_i         (en_q),
        .halt_i       (bus.halt_i),
        .halted_o     (halted),
        .all_halted_o (all_halted)
    );

    // Stagger count at which the highest enabled channel is released.
    always_comb begin
        last_rel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (en_q[i]) last_rel = CNT_IW'(i * STAGGER);
        end
    end

    // Next state, shared hold/stagger counter, run counter and enable latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        en_d    = en_q;
        if (bus.clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            cyc_d   = '0;
            en_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (start_ok) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        cyc_d   = '0;
                        en_d    = bus.ch_en;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == CNT_IW'(RST_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = (en_q == '0) ? ST_DONE : ST_STAGGER;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STAGGER: begin
                    if (cnt_q == last_rel) state_d = ST_RUN;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
                ST_RUN: begin
                    cyc_d = cyc_q + 1'b1;
                    if (all_halted)                               state_d = ST_DONE;
                    else if (cyc_q == CNT_W'(MAX_CYCLES - 1))     state_d = ST_TIMEOUT;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Core reset for the coming cycle; terminal states re-reset one cycle after entry.
    always_comb begin
        core_rst_d = '1;
        case (state_d)
            ST_STAGGER: begin
                for (int i = 0; i < N_CH; i++) begin
                    core_rst_d[i] = !(en_q[i] && (int'(cnt_d) >= i * STAGGER));
                end
            end
            ST_RUN: core_rst_d = ~en_q;
            ST_DONE, ST_TIMEOUT: begin
                if (state_q == ST_RUN) core_rst_d = core_rst_q;
            end
            default: core_rst_d = '1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cyc_q      <= '0;
            en_q       <= '0;
            core_rst_q <= '1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cyc_q      <= cyc_d;
            en_q       <= en_d;
            core_rst_q <= core_rst_d;
            running_q  <= (state_d == ST_RUN);
            done_q     <= (state_d == ST_DONE);
            timeout_q  <= (state_d == ST_TIMEOUT);
        end
    end

    assign bus.core_rst  = core_rst_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.halted    = halted;
    assign bus.cycle_cnt = cyc_q;
endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: a timeline model derived from the run rules.
module tb_run_ctrl;
    localparam int P_N   = 2;
    localparam int P_RST = 2;
    localparam int P_STG = 1;
    localparam int P_MAX = 40;
    localparam int P_W   = 16;
    localparam int B_RST = 2;
    localparam int B_MAX = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [P_N-1:0] halts [P_MAX];

    always #5 clk = ~clk;

    run_ctrl_if #(.N_CH(P_N), .CNT_W(P_W)) bus_a ();
    run_ctrl_if #(.N_CH(1),   .CNT_W(P_W)) bus_b ();

    run_ctrl #(.N_CH(P_N), .RST_CYCLES(P_RST), .STAGGER(P_STG), .MAX_CYCLES(P_MAX), .CNT_W(P_W))
        u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    run_ctrl #(.N_CH(1), .RST_CYCLES(B_RST), .STAGGER(0), .MAX_CYCLES(B_MAX), .CNT_W(P_W))
        u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full run on the main instance. Expected values come from the timeline:
    // hold RST cycles, channel i released i*STAGGER later, run starts the cycle
    // after the last release, ends on first full halt cover or on the budget.
    task automatic run_a(input string name, input logic [P_N-1:0] en,
                         input int abort_t, input bit abort_rst);
        logic [P_N-1:0] acc [P_MAX+1];
        logic [P_N-1:0] e_rst, e_halt;
        logic           e_run, e_done, e_to;
        logic [P_W-1:0] e_cnt;
        int             last, t_run, t_done, fin;
        bit             is_done;

        last = 0;
        for (int i = 0; i < P_N; i++) if (en[i]) last = i;
        acc[0]  = '0;
        fin     = P_MAX;
        is_done = 1'b0;
        for (int k = 0; k < P_MAX; k++) begin
            acc[k+1] = acc[k] | (halts[k] & en);
            if (!is_done && en != '0 && acc[k+1] == en) begin
                is_done = 1'b1;
                fin     = k + 1;
            end
        end
        if (en == '0) begin
            is_done = 1'b1;
            fin     = 0;
            t_run   = P_RST;
            t_done  = P_RST;
        end else begin
            t_run  = P_RST + last * P_STG + 1;
            t_done = t_run + fin;
        end

        bus_a.start  = 1'b1;
        bus_a.ch_en  = en;
        bus_a.halt_i = P_N'($urandom);
        tick();
        bus_a.start = 1'b0;

        for (int t = 0; t <= t_done + 2; t++) begin
            e_rst  = '1;
            e_run  = 1'b0;
            e_done = 1'b0;
            e_to   = 1'b0;
            e_halt = '0;
            e_cnt  = '0;
            if (t >= P_RST) begin
                if (en == '0) begin
                    e_done = 1'b1;
                end else if (t < t_run) begin
                    for (int i = 0; i < P_N; i++) e_rst[i] = !(en[i] && (t - P_RST) >= i * P_STG);
                end else if (t < t_done) begin
                    e_rst  = ~en;
                    e_run  = 1'b1;
                    e_cnt  = P_W'(t - t_run);
                    e_halt = acc[t - t_run];
                end else begin
                    e_rst  = (t == t_done) ? ~en : '1;
                    e_done = is_done;
                    e_to   = !is_done;
                    e_cnt  = P_W'(fin);
                    e_halt = acc[fin];
                end
            end
            n_chk++;
            if ({bus_a.core_rst, bus_a.running, bus_a.done, bus_a.timeout, bus_a.halted, bus_a.cycle_cnt}
                !== {e_rst, e_run, e_done, e_to, e_halt, e_cnt}) begin
                $display("FAIL %s t=%0d: got core_rst=%b run=%b done=%b timeout=%b halted=%b cnt=%0d, want core_rst=%b run=%b done=%b timeout=%b halted=%b cnt=%0d",
                         name, t, bus_a.core_rst, bus_a.running, bus_a.done, bus_a.timeout, bus_a.halted,
                         bus_a.cycle_cnt, e_rst, e_run, e_done, e_to, e_halt, e_cnt);
            end else begin
                n_pass++;
            end

            if (t == abort_t) begin
                if (abort_rst) begin
                    rst = 1'b0;
                    #1;
                end else begin
                    bus_a.clear = 1'b1;
                    bus_a.start = 1'b1;
                    tick();
                    bus_a.clear = 1'b0;
                    bus_a.start = 1'b0;
                end
                for (int j = 0; j < P_RST + 3; j++) begin
                    n_chk++;
                    if ({bus_a.core_rst, bus_a.running, bus_a.done, bus_a.timeout, bus_a.halted, bus_a.cycle_cnt}
                        !== {{P_N{1'b1}}, 3'b000, {P_N{1'b0}}, {P_W{1'b0}}}) begin
                        $display("FAIL %s abort+%0d: got core_rst=%b run=%b done=%b timeout=%b halted=%b cnt=%0d, want idle values",
                                 name, j, bus_a.core_rst, bus_a.running, bus_a.done, bus_a.timeout,
                                 bus_a.halted, bus_a.cycle_cnt);
                    end else begin
                        n_pass++;
                    end
                    if (j == 0 && abort_rst) begin
                        @(negedge clk);
                        rst = 1'b1;
                    end
                    bus_a.halt_i = P_N'($urandom);
                    tick();
                end
                return;
            end

            if (en != '0 && t >= t_run && t < t_done) bus_a.halt_i = halts[t - t_run];
            else                                      bus_a.halt_i = P_N'($urandom);
            bus_a.start = (t < t_done) && ($urandom_range(0, 3) == 0);
            bus_a.ch_en = P_N'($urandom);
            tick();
        end
        bus_a.start  = 1'b0;
        bus_a.halt_i = '0;
    endtask

    task automatic clear_halts();
        for (int k = 0; k < P_MAX; k++) halts[k] = '0;
    endtask

    task automatic test_reset();
        bus_a.start = 1'b0; bus_a.clear = 1'b0; bus_a.ch_en = '0; bus_a.halt_i = '0;
        bus_b.start = 1'b0; bus_b.clear = 1'b0; bus_b.ch_en = '0; bus_b.halt_i = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({bus_a.core_rst, bus_a.running, bus_a.done, bus_a.timeout, bus_a.halted, bus_a.cycle_cnt}
            !== {2'b11, 3'b000, 2'b00, 16'd0}) begin
            $display("FAIL reset_a: got core_rst=%b run=%b done=%b timeout=%b halted=%b cnt=%0d, want 11/0/0/0/00/0",
                     bus_a.core_rst, bus_a.running, bus_a.done, bus_a.timeout, bus_a.halted, bus_a.cycle_cnt);
        end else n_pass++;
        n_chk++;
        if ({bus_b.core_rst, bus_b.running, bus_b.done, bus_b.timeout, bus_b.halted, bus_b.cycle_cnt}
            !== {1'b1, 3'b000, 1'b0, 16'd0}) begin
            $display("FAIL reset_b: got core_rst=%b run=%b done=%b timeout=%b halted=%b cnt=%0d, want 1/0/0/0/0/0",
                     bus_b.core_rst, bus_b.running, bus_b.done, bus_b.timeout, bus_b.halted, bus_b.cycle_cnt);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic(input string name);
        clear_halts();
        halts[5] = 2'b01;
        halts[8] = 2'b10;
        run_a(name, 2'b11, -1, 1'b0);
    endtask

    task automatic test_timeout();
        clear_halts();
        run_a("timeout", 2'b11, -1, 1'b0);
    endtask

    task automatic test_partial_enable();
        for (int k = 0; k < P_MAX; k++) halts[k] = {1'($urandom), 1'b0};
        halts[12] = 2'b11;
        run_a("partial_enable", 2'b01, -1, 1'b0);
    endtask

    task automatic test_simultaneous();
        clear_halts();
        halts[3]         = 2'b01;
        halts[P_MAX - 1] = 2'b10;
        run_a("done_beats_timeout", 2'b11, -1, 1'b0);
    endtask

    task automatic test_abort();
        clear_halts();
        halts[4] = 2'b01;
        run_a("clear_in_run", 2'b11, (P_RST + P_STG + 1) + 10, 1'b0);
        test_basic("restart_after_clear");
        run_a("rst_in_stagger", 2'b11, P_RST, 1'b1);
        test_basic("restart_after_rst");
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < P_MAX; k++)
                halts[k] = ($urandom_range(0, 9) == 0) ? P_N'($urandom) : '0;
            run_a("random", P_N'($urandom), -1, 1'b0);
        end
    endtask

    // Single-core instance with no stagger and a short budget; r==3 runs with no channel enabled.
    task automatic test_edge_params();
        int   hk, t_run, t_done, fin;
        bit   is_done;
        logic e_rst, e_run, e_done, e_to, e_halt;
        logic [P_W-1:0] e_cnt;
        run_a("a_no_enable", 2'b00, -1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            hk      = (r == 0) ? int'($urandom_range(0, B_MAX - 2)) : (r == 1) ? B_MAX - 1 : -1;
            is_done = (hk >= 0) || (r == 3);
            if (r == 3) begin
                t_run  = B_RST;
                fin    = 0;
                t_done = B_RST;
            end else begin
                t_run  = B_RST + 1;
                fin    = (hk >= 0) ? hk + 1 : B_MAX;
                t_done = t_run + fin;
            end
            bus_b.start = 1'b1;
            bus_b.ch_en = (r != 3);
            tick();
            bus_b.start = 1'b0;
            for (int t = 0; t <= t_done + 2; t++) begin
                e_rst  = !(r != 3 && t >= B_RST && t <= t_done);
                e_run  = (r != 3) && t >= t_run && t < t_done;
                e_done = (t >= t_done) && is_done;
                e_to   = (t >= t_done) && !is_done;
                e_cnt  = (t < t_run) ? '0 : (t < t_done) ? P_W'(t - t_run) : P_W'(fin);
                e_halt = (t >= t_done) && (hk >= 0);
                n_chk++;
                if ({bus_b.core_rst, bus_b.running, bus_b.done, bus_b.timeout, bus_b.halted, bus_b.cycle_cnt}
                    !== {e_rst, e_run, e_done, e_to, e_halt, e_cnt}) begin
                    $display("FAIL edge_b run=%0d t=%0d: got core_rst=%b run=%b done=%b timeout=%b halted=%b cnt=%0d, want core_rst=%b run=%b done=%b timeout=%b halted=%b cnt=%0d",
                             r, t, bus_b.core_rst, bus_b.running, bus_b.done, bus_b.timeout, bus_b.halted,
                             bus_b.cycle_cnt, e_rst, e_run, e_done, e_to, e_halt, e_cnt);
                end else n_pass++;
                bus_b.halt_i = (hk >= 0 && t == t_run + hk) || (t < t_run) || (t >= t_done);
                tick();
            end
            bus_b.halt_i = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_timeout();
        test_partial_enable();
        test_simultaneous();
        test_abort();
        test_random();
        test_edge_params();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
